// File: rtl/regfile_param.sv
// Parametrised CSR bank: per-register RW / RO / W1C behaviour, byte-enabled writes,
// registered read port and W1C-driven irq. Optional access-error pulse under REGFILE_ERR_EN.
module regfile_param #(
    parameter int                              DATA_W    = 32,
    parameter int                              ADDR_W    = 8,
    parameter int                              NUM_REGS  = 16,
    parameter logic [NUM_REGS-1:0]             RO_MASK   = '0,
    parameter logic [NUM_REGS-1:0]             W1C_MASK  = '0,
    parameter logic [NUM_REGS*DATA_W-1:0]      RST_VAL   = '0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wr_en,
    input  logic [ADDR_W-1:0]                  wr_addr,
    input  logic [DATA_W-1:0]                  wr_data,
    input  logic [DATA_W/8-1:0]                wr_be,
    input  logic                               rd_en,
    input  logic [ADDR_W-1:0]                  rd_addr,
    output logic [DATA_W-1:0]                  rd_data,
    output logic                               rd_valid,
    input  logic [NUM_REGS*DATA_W-1:0]         hw_status,
    input  logic [NUM_REGS*DATA_W-1:0]         hw_set,
    output logic [NUM_REGS*DATA_W-1:0]         reg_out,
    output logic                               irq,
    output logic                               err
);

    localparam int NB  = DATA_W / 8;
    localparam int OFF = $clog2(NB);

    // RO takes priority, so a register flagged both ways is treated as RO only.
    localparam logic [NUM_REGS-1:0] RO_EFF  = RO_MASK;
    localparam logic [NUM_REGS-1:0] W1C_EFF = W1C_MASK & ~RO_MASK;

    logic [DATA_W-1:0]   regs     [NUM_REGS];
    logic [DATA_W-1:0]   reg_nxt  [NUM_REGS];
    logic [ADDR_W-1:0]   wr_idx;
    logic [ADDR_W-1:0]   rd_idx;
    logic [NUM_REGS-1:0] wr_hit;
    logic [NUM_REGS-1:0] rd_hit;
    logic [DATA_W-1:0]   be_mask;
    logic [DATA_W-1:0]   wr_clr;
    logic [DATA_W-1:0]   rd_word;
    logic [DATA_W-1:0]   w1c_or;

    assign wr_idx = wr_addr >> OFF;
    assign rd_idx = rd_addr >> OFF;

    always_comb begin
        be_mask = '0;
        for (int b = 0; b < NB; b++) begin
            be_mask[b*8 +: 8] = {8{wr_be[b]}};
        end
    end

    assign wr_clr = wr_data & be_mask;

    // Index decode; an index with no hit is unmapped and touches nothing.
    always_comb begin
        wr_hit = '0;
        rd_hit = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_hit[i] = wr_en && (wr_idx == ADDR_W'(i));
            rd_hit[i] = rd_idx == ADDR_W'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_nxt[i] = regs[i];
            if (RO_EFF[i]) begin
                reg_nxt[i] = hw_status[i*DATA_W +: DATA_W];
            end else if (W1C_EFF[i]) begin
                // Set is OR'd in after the clear so a coincident set wins.
                reg_nxt[i] = (regs[i] & ~(wr_hit[i] ? wr_clr : '0))
                           | hw_set[i*DATA_W +: DATA_W];
            end else if (wr_hit[i]) begin
                reg_nxt[i] = (regs[i] & ~be_mask) | (wr_data & be_mask);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rst) begin
                regs[i] <= RST_VAL[i*DATA_W +: DATA_W];
            end else begin
                regs[i] <= reg_nxt[i];
            end
        end
    end

    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_out[i*DATA_W +: DATA_W] = regs[i];
        end
    end

    always_comb begin
        rd_word = '0;
        w1c_or  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_hit[i]) begin
                rd_word = rd_word | regs[i];
            end
            if (W1C_EFF[i]) begin
                w1c_or = w1c_or | regs[i];
            end
        end
    end

    // Read handshake: rd_en is always accepted (no ready); the request made at an edge
    // returns the pre-edge contents with rd_valid high for exactly the following cycle.
    // rd_data holds its last value whenever rd_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            irq      <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_word;
            end
            irq <= |w1c_or;
        end
    end

`ifdef REGFILE_ERR_EN
    logic wr_err;
    logic rd_err;
    logic err_q;

    assign wr_err = wr_en && (~|wr_hit || |(wr_hit & RO_EFF));
    assign rd_err = rd_en && ~|rd_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= wr_err || rd_err;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: reg0 RW (reset 0xAABBCCDD), reg1 RW, reg2 RW (reset 0xDEADBEEF),
// reg3 W1C, reg5 RO, NUM_REGS=16 so byte address 0x40 is unmapped.
module tb_regfile_param;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NR = 16;
    localparam logic [NR-1:0]    RO_M  = 16'h0020;
    localparam logic [NR-1:0]    W1C_M = 16'h0008;
    localparam logic [NR*DW-1:0] RSTV  = {{13{32'h0}}, 32'hDEADBEEF, 32'h0, 32'hAABBCCDD};

`ifdef REGFILE_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic [DW/8-1:0] wr_be;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic [DW-1:0]   rd_data;
    logic            rd_valid;
    logic [NR*DW-1:0] hw_status;
    logic [NR*DW-1:0] hw_set;
    logic [NR*DW-1:0] reg_out;
    logic            irq;
    logic            err;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];

    regfile_param #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR),
        .RO_MASK(RO_M), .W1C_MASK(W1C_M), .RST_VAL(RSTV)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .hw_status(hw_status), .hw_set(hw_set), .reg_out(reg_out),
        .irq(irq), .err(err)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
        total++; if (reg_out !== RSTV) begin bad++; $display("FAIL reset_reg_out got=%h exp=%h", reg_out, RSTV); end
        do_read(8'h08);
        total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL reset_read_valid got=%b exp=1", rd_valid); end
        total++; if (rd_data !== 32'hDEADBEEF) begin bad++; $display("FAIL reset_read_data got=%h exp=deadbeef", rd_data); end
        tick();
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL read_valid_drop got=%b exp=0", rd_valid); end
        total++; if (rd_data !== 32'hDEADBEEF) begin bad++; $display("FAIL read_data_hold got=%h exp=deadbeef", rd_data); end
    endtask

    task automatic test_rw_be();
        do_write(8'h00, 32'h11223344, 4'b0101);
        total++; if (reg_out[0 +: 32] !== 32'hAA22CC44) begin bad++; $display("FAIL rw_be_reg_out got=%h exp=aa22cc44", reg_out[0 +: 32]); end
        do_read(8'h02);
        total++; if (rd_data !== 32'hAA22CC44) begin bad++; $display("FAIL rw_be_read got=%h exp=aa22cc44", rd_data); end
        // Low address bits are ignored: 0x07 lands on register 1.
        do_write(8'h07, 32'h00000055, 4'b1111);
        total++; if (reg_out[32 +: 32] !== 32'h55) begin bad++; $display("FAIL rw_low_bits got=%h exp=00000055", reg_out[32 +: 32]); end
    endtask

    task automatic test_w1c();
        hw_set[3*32 +: 32] = 32'h5;
        tick();
        hw_set = '0;
        total++; if (reg_out[96 +: 32] !== 32'h5) begin bad++; $display("FAIL w1c_set got=%h exp=00000005", reg_out[96 +: 32]); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL w1c_irq_early got=%b exp=0", irq); end
        tick();
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL w1c_irq_rise got=%b exp=1", irq); end
        do_write(8'h0C, 32'h1, 4'b1111);
        total++; if (reg_out[96 +: 32] !== 32'h4) begin bad++; $display("FAIL w1c_clr1 got=%h exp=00000004", reg_out[96 +: 32]); end
        tick();
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL w1c_irq_hold got=%b exp=1", irq); end
        do_write(8'h0C, 32'h4, 4'b1111);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL w1c_irq_lag got=%b exp=1", irq); end
        tick();
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL w1c_irq_fall got=%b exp=0", irq); end
        hw_set[3*32 +: 32] = 32'h8;
        do_write(8'h0C, 32'h8, 4'b1111);
        hw_set = '0;
        total++; if (reg_out[96 +: 32] !== 32'h8) begin bad++; $display("FAIL w1c_set_wins got=%h exp=00000008", reg_out[96 +: 32]); end
        do_write(8'h0C, 32'h8, 4'b0000);
        total++; if (reg_out[96 +: 32] !== 32'h8) begin bad++; $display("FAIL w1c_be_zero got=%h exp=00000008", reg_out[96 +: 32]); end
        do_write(8'h0C, 32'h8, 4'b0001);
        tick();
        total++; if (reg_out[96 +: 32] !== 32'h0) begin bad++; $display("FAIL w1c_clr_all got=%h exp=0", reg_out[96 +: 32]); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL w1c_irq_final got=%b exp=0", irq); end
    endtask

    task automatic test_ro();
        hw_status[5*32 +: 32] = 32'h0000CAFE;
        tick();
        total++; if (reg_out[160 +: 32] !== 32'h0000CAFE) begin bad++; $display("FAIL ro_capture got=%h exp=0000cafe", reg_out[160 +: 32]); end
        do_write(8'h14, 32'hFFFFFFFF, 4'b1111);
        total++; if (err !== ERR_EXP) begin bad++; $display("FAIL ro_err got=%b exp=%b", err, ERR_EXP); end
        total++; if (reg_out[160 +: 32] !== 32'h0000CAFE) begin bad++; $display("FAIL ro_write_ignored got=%h exp=0000cafe", reg_out[160 +: 32]); end
        tick();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL ro_err_pulse got=%b exp=0", err); end
        do_read(8'h14);
        total++; if (rd_data !== 32'h0000CAFE) begin bad++; $display("FAIL ro_read got=%h exp=0000cafe", rd_data); end
    endtask

    task automatic test_unmapped();
        logic [NR*DW-1:0] exp_out;
        exp_out = '0;
        exp_out[0   +: 32] = 32'hAA22CC44;
        exp_out[32  +: 32] = 32'h00000055;
        exp_out[64  +: 32] = 32'hDEADBEEF;
        exp_out[160 +: 32] = 32'h0000CAFE;
        do_write(8'h40, 32'hFFFFFFFF, 4'b1111);
        total++; if (reg_out !== exp_out) begin bad++; $display("FAIL unmapped_write got=%h exp=%h", reg_out, exp_out); end
        total++; if (err !== ERR_EXP) begin bad++; $display("FAIL unmapped_wr_err got=%b exp=%b", err, ERR_EXP); end
        do_read(8'h40);
        total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL unmapped_valid got=%b exp=1", rd_valid); end
        total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL unmapped_read got=%h exp=0", rd_data); end
        total++; if (err !== ERR_EXP) begin bad++; $display("FAIL unmapped_rd_err got=%b exp=%b", err, ERR_EXP); end
    endtask

    task automatic test_rd_during_wr();
        do_write(8'h04, 32'h1, 4'b1111);
        wr_en = 1'b1; wr_addr = 8'h04; wr_data = 32'h2; wr_be = 4'b1111;
        rd_en = 1'b1; rd_addr = 8'h04;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        total++; if (rd_data !== 32'h1) begin bad++; $display("FAIL rdwr_old got=%h exp=00000001", rd_data); end
        do_read(8'h04);
        total++; if (rd_data !== 32'h2) begin bad++; $display("FAIL rdwr_new got=%h exp=00000002", rd_data); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] addrs [3];
        logic [DW-1:0] got;
        addrs[0] = 8'h00; addrs[1] = 8'h08; addrs[2] = 8'h14;
        exp_q.push_back(32'hAA22CC44);
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'h0000CAFE);
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_addr = addrs[i];
            tick();
            got = exp_q.pop_front();
            total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, rd_valid); end
            total++; if (rd_data !== got) begin bad++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, rd_data, got); end
        end
        rd_en = 1'b0;
        tick();
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL b2b_valid_end got=%b exp=0", rd_valid); end
    endtask

    task automatic test_reset_mid();
        hw_set[3*32 +: 32] = 32'h1;
        tick();
        hw_set = '0;
        tick();
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL mid_irq_pre got=%b exp=1", irq); end
        rst = 1'b1;
        wr_en = 1'b1; wr_addr = 8'h00; wr_data = 32'h12345678; wr_be = 4'b1111;
        rd_en = 1'b1; rd_addr = 8'h40;
        hw_set[3*32 +: 32] = 32'hF;
        tick();
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; hw_set = '0;
        total++; if (reg_out !== RSTV) begin bad++; $display("FAIL mid_reg_out got=%h exp=%h", reg_out, RSTV); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL mid_rd_valid got=%b exp=0", rd_valid); end
        total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL mid_rd_data got=%h exp=0", rd_data); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL mid_irq got=%b exp=0", irq); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL mid_err got=%b exp=0", err); end
        tick();
        total++; if (reg_out[160 +: 32] !== 32'h0000CAFE) begin bad++; $display("FAIL mid_ro_reload got=%h exp=0000cafe", reg_out[160 +: 32]); end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = 1'b0; rd_addr = '0; hw_status = '0; hw_set = '0;
        test_reset();
        test_rw_be();
        test_w1c();
        test_ro();
        test_unmapped();
        test_rd_during_wr();
        // Register 1 now holds 0x2; restore the value test_unmapped assumed is no longer needed.
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
